// File: rtl/vga_scan_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_timing
// Description : Raster scan generator. Produces DrawX/DrawY/blank for the
//               sprite renderers, takes their RGB back PIPE_DELAY cycles
//               later and drives the VGA pins. hs/vs travel through a delay
//               line so they stay aligned with the pin colour.
// Options     : VGA_TEST_PATTERN_EN - adds test_mode input and an internal
//               8-bar colour pattern (bar = DrawX/80).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_timing #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  // Renderer latency from DrawX/DrawY to valid RGB in; legal range 0..3.
  parameter int PIPE_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       frame_start,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs
);

  localparam int         c_H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int         c_V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] c_V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] c_HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] c_HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] c_VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic       r_hs0;
  logic       r_vs0;

  // Delayed stage-0 qualifiers, aligned with the renderer's RGB.
  logic       w_blank_d;
  logic       w_hs_d;
  logic       w_vs_d;

  // Colour source selected for the output register.
  logic [3:0] w_src_r;
  logic [3:0] w_src_g;
  logic [3:0] w_src_b;

  // Horizontal/vertical counters; vc advances on the hc wrap edge.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hc <= 10'd0;
      r_vc <= 10'd0;
    end else if (r_hc == c_H_LAST) begin
      r_hc <= 10'd0;
      r_vc <= (r_vc == c_V_LAST) ? 10'd0 : r_vc + 10'd1;
    end else begin
      r_hc <= r_hc + 10'd1;
    end
  end

  // Stage 0: coordinates and qualifiers registered from the counters.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      r_hs0       <= 1'b1;
      r_vs0       <= 1'b1;
    end else begin
      DrawX       <= r_hc;
      DrawY       <= r_vc;
      blank       <= (r_hc < c_H_VIS) && (r_vc < c_V_VIS);
      frame_start <= (r_hc == 10'd0) && (r_vc == 10'd0);
      r_hs0       <= !((r_hc >= c_HS_FIRST) && (r_hc <= c_HS_LAST));
      r_vs0       <= !((r_vc >= c_VS_FIRST) && (r_vc <= c_VS_LAST));
    end
  end

  // Qualifier delay line matching the renderer latency.
  if (PIPE_DELAY == 0) begin : g_no_delay
    assign w_blank_d = blank;
    assign w_hs_d    = r_hs0;
    assign w_vs_d    = r_vs0;
  end else begin : g_delay
    logic [PIPE_DELAY-1:0] r_blank_sr;
    logic [PIPE_DELAY-1:0] r_hs_sr;
    logic [PIPE_DELAY-1:0] r_vs_sr;

    // Shift blank/hs/vs one stage per cycle; reset to the idle levels.
    always_ff @(posedge vga_clk) begin
      if (reset) begin
        r_blank_sr <= '0;
        r_hs_sr    <= '1;
        r_vs_sr    <= '1;
      end else begin
        r_blank_sr[0] <= blank;
        r_hs_sr[0]    <= r_hs0;
        r_vs_sr[0]    <= r_vs0;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          r_blank_sr[i] <= r_blank_sr[i-1];
          r_hs_sr[i]    <= r_hs_sr[i-1];
          r_vs_sr[i]    <= r_vs_sr[i-1];
        end
      end
    end

    assign w_blank_d = r_blank_sr[PIPE_DELAY-1];
    assign w_hs_d    = r_hs_sr[PIPE_DELAY-1];
    assign w_vs_d    = r_vs_sr[PIPE_DELAY-1];
  end

`ifdef VGA_TEST_PATTERN_EN
  // Bar index of the current stage-0 column; only meaningful while visible.
  logic [2:0] w_bar;
  logic [2:0] w_bar_d;

  // Eight vertical bars, 80 columns wide each.
  always_comb begin
    w_bar = 3'(DrawX / 10'd80);
  end

  if (PIPE_DELAY == 0) begin : g_bar_no_delay
    assign w_bar_d = w_bar;
  end else begin : g_bar_delay
    logic [2:0] r_bar_sr [PIPE_DELAY];

    // Bar index travels alongside blank so it lines up with the pin stage.
    always_ff @(posedge vga_clk) begin
      if (reset) begin
        for (int i = 0; i < PIPE_DELAY; i++) begin
          r_bar_sr[i] <= 3'd0;
        end
      end else begin
        r_bar_sr[0] <= w_bar;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          r_bar_sr[i] <= r_bar_sr[i-1];
        end
      end
    end

    assign w_bar_d = r_bar_sr[PIPE_DELAY-1];
  end
`endif

  // Pick the colour source: renderer inputs, or the bar pattern in test mode.
  always_comb begin
    w_src_r = red_in;
    w_src_g = green_in;
    w_src_b = blue_in;
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode) begin
      w_src_r = w_bar_d[2] ? 4'hF : 4'h0;
      w_src_g = w_bar_d[1] ? 4'hF : 4'h0;
      w_src_b = w_bar_d[0] ? 4'hF : 4'h0;
    end
`endif
  end

  // Pin register: colour gated to black outside the visible area.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vga_r  <= 4'h0;
      vga_g  <= 4'h0;
      vga_b  <= 4'h0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      vga_r  <= w_blank_d ? w_src_r : 4'h0;
      vga_g  <= w_blank_d ? w_src_g : 4'h0;
      vga_b  <= w_blank_d ? w_src_b : 4'h0;
      vga_hs <= w_hs_d;
      vga_vs <= w_vs_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scan_timing
// Description : Self-checking bench for vga_scan_timing. Four instances:
//               three with a reduced raster (PIPE_DELAY 0/1/3) that run
//               several frames, one with default 640x480 timing for the
//               first lines. A pixel-index reference model predicts every
//               output every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_timing;

  // Reduced raster: 24 x 11 = 264 cycles per frame.
  localparam int SHV = 16, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVV = 6,  SVF = 1, SVS = 2, SVB = 2;
  localparam int SFRAME = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tm = 1'b0;
  logic [3:0] rin = 4'h0, gin = 4'h0, bin = 4'h0;

  logic [9:0] dx [4];
  logic [9:0] dy [4];
  logic       bl [4];
  logic       fs [4];
  logic [3:0] pr [4];
  logic [3:0] pg [4];
  logic [3:0] pb [4];
  logic       phs [4];
  logic       pvs [4];

  int checks = 0;
  int errors = 0;
  int n = 0;          // edges since reset was released (0 = in reset)
  int seg = 0;        // run segment, bumped on each mid-run reset
  int last_fs = -1;
  int s_hs_low = 0, s_vs_low = 0, s_blank = 0;
  int f_hs_low = 0, f_blank = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam bit FULL = (k == 3);
    vga_scan_timing #(
      .H_VISIBLE (FULL ? 640 : SHV),
      .H_FP      (FULL ? 16  : SHF),
      .H_SYNC    (FULL ? 96  : SHS),
      .H_BP      (FULL ? 48  : SHB),
      .V_VISIBLE (FULL ? 480 : SVV),
      .V_FP      (FULL ? 10  : SVF),
      .V_SYNC    (FULL ? 2   : SVS),
      .V_BP      (FULL ? 33  : SVB),
      .PIPE_DELAY(k == 0 ? 0 : (k == 2 ? 3 : 1))
    ) u_dut (
      .vga_clk    (clk),
      .reset      (reset),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode  (tm),
`endif
      .red_in     (rin),
      .green_in   (gin),
      .blue_in    (bin),
      .DrawX      (dx[k]),
      .DrawY      (dy[k]),
      .blank      (bl[k]),
      .frame_start(fs[k]),
      .vga_r      (pr[k]),
      .vga_g      (pg[k]),
      .vga_b      (pb[k]),
      .vga_hs     (phs[k]),
      .vga_vs     (pvs[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference model: stage 0 shows pixel n-1, pins show pixel n-D-2 with the
  // colour that was on the inputs at the latest edge.
  task automatic check_dut(input int k);
    int d, hv, hf, hs, hb, vv, vf, vs, vb, ht, vt, fr, p, x, y, bar;
    logic [9:0] ex, ey;
    logic eb, efs, ehs, evs, vis;
    logic [3:0] er, eg, ebb;
    string t;
    d  = (k == 0) ? 0 : ((k == 2) ? 3 : 1);
    hv = (k == 3) ? 640 : SHV; hf = (k == 3) ? 16 : SHF;
    hs = (k == 3) ? 96  : SHS; hb = (k == 3) ? 48 : SHB;
    vv = (k == 3) ? 480 : SVV; vf = (k == 3) ? 10 : SVF;
    vs = (k == 3) ? 2   : SVS; vb = (k == 3) ? 33 : SVB;
    ht = hv + hf + hs + hb; vt = vv + vf + vs + vb; fr = ht * vt;

    ex = '0; ey = '0; eb = 1'b0; efs = 1'b0;
    if (n > 0) begin
      p = (n - 1) % fr; x = p % ht; y = p / ht;
      ex = 10'(x); ey = 10'(y); eb = (x < hv) && (y < vv); efs = (p == 0);
    end

    er = 4'h0; eg = 4'h0; ebb = 4'h0; ehs = 1'b1; evs = 1'b1;
    p = n - d - 2;
    if (n > 0 && p >= 0) begin
      p = p % fr; x = p % ht; y = p / ht;
      vis = (x < hv) && (y < vv);
      ehs = !(x >= hv + hf && x < hv + hf + hs);
      evs = !(y >= vv + vf && y < vv + vf + vs);
      if (vis) begin
        er = rin; eg = gin; ebb = bin;
`ifdef VGA_TEST_PATTERN_EN
        if (tm) begin
          bar = x / 80;
          er = bar[2] ? 4'hF : 4'h0;
          eg = bar[1] ? 4'hF : 4'h0;
          ebb = bar[0] ? 4'hF : 4'h0;
        end
`endif
      end
    end

    t = $sformatf("dut%0d n=%0d", k, n);
    chk({t, " DrawX"}, 32'(dx[k]), 32'(ex));
    chk({t, " DrawY"}, 32'(dy[k]), 32'(ey));
    chk({t, " blank"}, 32'(bl[k]), 32'(eb));
    chk({t, " frame_start"}, 32'(fs[k]), 32'(efs));
    chk({t, " vga_r"}, 32'(pr[k]), 32'(er));
    chk({t, " vga_g"}, 32'(pg[k]), 32'(eg));
    chk({t, " vga_b"}, 32'(pb[k]), 32'(ebb));
    chk({t, " vga_hs"}, 32'(phs[k]), 32'(ehs));
    chk({t, " vga_vs"}, 32'(pvs[k]), 32'(evs));
  endtask

  // One clock: drive inputs while clk is low, check 1 time unit after the edge.
  task automatic tick(input logic rst_v, input logic [3:0] r, input logic [3:0] g,
                      input logic [3:0] b, input logic t);
    @(negedge clk);
    reset = rst_v; rin = r; gin = g; bin = b; tm = t;
    @(posedge clk);
    #1;
    if (rst_v) begin
      n = 0; last_fs = -1;
    end else begin
      n = n + 1;
    end
    for (int k = 0; k < 4; k++) check_dut(k);

    if (fs[1]) begin
      if (last_fs >= 0) chk("frame_start period", 32'(n - last_fs), 32'(SFRAME));
      last_fs = n;
    end
    if (seg == 0 && n >= 10 && n < 10 + 2 * SFRAME) begin
      s_hs_low += (phs[1] == 1'b0) ? 1 : 0;
      s_vs_low += (pvs[1] == 1'b0) ? 1 : 0;
      s_blank  += (bl[1] == 1'b1) ? 1 : 0;
    end
    if (seg == 0 && n >= 10 && n < 1610) f_hs_low += (phs[3] == 1'b0) ? 1 : 0;
    if (seg == 0 && n >= 1 && n <= 1600) f_blank += (bl[3] == 1'b1) ? 1 : 0;
  endtask

  task automatic tick_rand(input logic t);
    tick(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
         4'($urandom_range(0, 15)), t);
  endtask

  initial begin
    int guard;

    // Reset held for 5 cycles, even with live-looking inputs.
    for (int i = 0; i < 5; i++) tick(1'b1, 4'hF, 4'hF, 4'hF, 1'b0);

    // First frames: random colour; test pattern active for the first line.
    for (int i = 0; i < 1700; i++) begin
`ifdef VGA_TEST_PATTERN_EN
      tick_rand(n < 820);
`else
      tick_rand(1'b0);
`endif
    end

    chk("small 2-frame hs low cycles", 32'(s_hs_low), 32'(2 * 11 * SHS));
    chk("small 2-frame vs low cycles", 32'(s_vs_low), 32'(2 * SVS * 24));
    chk("small 2-frame blank cycles", 32'(s_blank), 32'(2 * SHV * SVV));
    chk("full 2-line hs low cycles", 32'(f_hs_low), 32'(2 * 96));
    chk("full 2-line blank cycles", 32'(f_blank), 32'(2 * 640));

    // Saturated inputs: porches and sync must still read black.
    for (int i = 0; i < 300; i++) tick(1'b0, 4'hF, 4'hF, 4'hF, 1'b0);

    // Run to DrawX=10, DrawY=3 on the small raster, then pulse reset.
    guard = 0;
    while ((n % SFRAME) != 83 && guard < 2 * SFRAME) begin
      tick_rand(1'b0);
      guard++;
    end
    chk("reach mid-frame reset point", 32'(n % SFRAME), 32'd83);
    seg = 1;
    tick(1'b1, 4'hF, 4'hF, 4'hF, 1'b0);
    tick(1'b0, 4'hF, 4'hF, 4'hF, 1'b0);
    chk("frame_start right after reset release", 32'(fs[1]), 32'd1);
    chk("no stale colour after reset", 32'(pr[2]), 32'd0);

    for (int i = 0; i < 600; i++) tick_rand(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
